adc_spi_reader: RTL and testbench
=================================

Name: adc_spi_reader

Overview:
SPI master for the 8-channel, 12-bit ADC128S022-style ADC. It consumes the registered 3-bit channel select produced by the channel-select/LED block and runs 16-bit SPI frames. Each frame sends the channel address on MOSI and shifts the conversion result in on MISO. The result is presented to downstream capture/display logic as a 1-cycle valid pulse tagged with its channel.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period; legal range 3..255, because MISO passes through a 2-FF synchronizer
CS_GAP, 2, clk cycles cs_n stays high between frames; legal range 1..255
DATA_W, 12, ADC result width

Ports:
clk  in  1  system clock
resetn  in  1  reset, synchronous, active-low
en  in  1  level; while high, frames run back-to-back
channel_addr  in  3  channel select from the channel-select block
sclk  out  1  SPI clock, CPOL=1 (idle high)
cs_n  out  1  ADC chip select, active-low
mosi  out  1  ADC DIN
miso  in  1  ADC DOUT, asynchronous
sample_data  out  DATA_W  last conversion result
sample_chan  out  3  channel that sample_data belongs to
sample_valid  out  1  1-cycle pulse: new sample_data/sample_chan
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: clk only; reset is synchronous, active-low (resetn).
- Reset values: sclk=1, cs_n=1, mosi=0, sample_data=0, sample_chan=0, sample_valid=0, busy=0, prev_chan=0, state=IDLE.
- All outputs are registered.
- FSM: IDLE -> SETUP -> SHIFT -> GAP -> IDLE.
- IDLE:
  - en=1 sampled at cycle 0 -> cycle 1: cs_n=0, state SETUP.
  - channel_addr is latched into cur_chan on this transition.
  - Changes to channel_addr during a frame are ignored.
- SETUP: CLK_DIV cycles with sclk=1, cs_n=0, mosi=0.
- SHIFT: 16 SCLK periods, k=0..15. Each period is a low phase (CLK_DIV cycles, sclk=0) followed by a high phase (CLK_DIV cycles, sclk=1).
  - mosi updates on the cycle sclk falls.
  - mosi = cur_chan[2] for k=2, cur_chan[1] for k=3, cur_chan[0] for k=4; 0 for all other k.
  - MISO is double-flopped. The synchronized value is shifted into a 16-bit register (MSB first) on the last cycle of each high phase.
- Default timing: period k low phase occupies cycles 5+8k..8+8k; high phase occupies 9+8k..12+8k; last sample taken at cycle 132.
- SHIFT -> GAP on the cycle after the last high-phase cycle (cycle 133 default). On that cycle:
  - cs_n=1, sclk=1, mosi=0, sample_valid=1.
  - sample_data = shift[DATA_W-1:0]; the 4 leading zero bits are discarded.
  - sample_chan = prev_chan, then prev_chan <= cur_chan. The ADC returns the conversion selected in the previous frame; the first frame after reset reports channel 0.
- GAP: CS_GAP cycles with cs_n=1, then IDLE. Next frame cs_n falls 1 cycle later if en=1.
- Frame period: 1 + CLK_DIV + 32*CLK_DIV + CS_GAP (135 cycles default).
- sample_valid is low in all cycles except the single cycle above. sample_data and sample_chan hold until the next valid.
- en deasserted mid-frame: the frame completes normally, including sample_valid, then the block stays in IDLE.
- Reset mid-frame: reset values apply on the next clk edge. No sample_valid is produced and the partial data is discarded.
- Counters: half-period counter is 8-bit; bit counter is 4-bit. Bit-counter wrap from 15 ends SHIFT.

Decomposition:
- Package adc_spi_pkg holds:
  - state enum {IDLE, SETUP, SHIFT, GAP}
  - FRAME_BITS=16
  - ADDR_FIRST_BIT=2
  - ADC_LEAD_ZEROS=4
  - ADC_DATA_W=12
- One sub-module, spi_sclk_gen: a half-period counter producing fall_tick/rise_tick/last_high strobes under an enable. The FSM, shift register and synchronizer stay in adc_spi_reader.

Test Plan:
1. Reset, then en=1, channel_addr=3'b101, ADC model returning 0x0ABC:
   - cs_n falls at cycle 1, first sclk fall at cycle 5.
   - mosi carries bits 1,0,1 in periods 2..4.
   - sample_valid at cycle 133, sample_chan=0 (first frame).
2. Continuous en=1, channel_addr sequence 2,6,1:
   - frames 135 cycles apart.
   - reported sample_chan sequence 0,2,6, each with the matching model data (0x123, 0xFFF, 0x000).
3. channel_addr toggles 7->0 mid-frame: mosi address bits stay 1,1,1; cur_chan=7 reported on the next frame.
4. en dropped at cycle 50 of a frame: frame finishes, sample_valid at cycle 133, busy low from cycle 135, cs_n stays high.
5. resetn low at cycle 70 mid-SHIFT: next cycle cs_n=1, sclk=1, mosi=0, no sample_valid; a new frame after reset reports sample_chan=0.
6. CLK_DIV=3, CS_GAP=1, miso changing 1 clk after each sclk fall: sample_data is bit-exact (0x5A5); period is 1+3+96+1=101 cycles.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the ADC128S022-style SPI reader.
// Frame layout: 16 SCLK periods, channel address in periods 2..4.
package adc_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } state_e;

  localparam int FRAME_BITS     = 16;
  localparam int ADDR_FIRST_BIT = 2;
  localparam int ADC_LEAD_ZEROS = 4;
  localparam int ADC_DATA_W     = 12;

  // DIN value for SCLK period k: channel address MSB first, else 0
  function automatic logic addr_bit(
    input logic [3:0] k,
    input logic [2:0] chan
  );
    logic [3:0] rel;
    rel      = k - 4'(ADDR_FIRST_BIT);
    addr_bit = 1'b0;
    if (rel < 4'd3) begin
      addr_bit = chan[2'd2 - rel[1:0]];
    end
  endfunction

endpackage

// File: rtl/adc_spi_reader_sclk_gen.sv
// Half-period counter for SCLK; SETUP is treated as a high phase.
// Strobes mark the last clk cycle of each phase.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic en_i,
  input  logic stop_i,
  output logic fall_tick_o,
  output logic rise_tick_o,
  output logic last_high_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       high_q, high_d;
  logic       wrap;

  assign wrap = (cnt_q == 8'(CLK_DIV - 1));

  always_comb begin
    cnt_d  = cnt_q;
    high_d = high_q;
    if (!en_i) begin
      cnt_d  = '0;
      high_d = 1'b1;
    end else if (wrap) begin
      cnt_d  = '0;
      high_d = ~high_q;
    end else begin
      cnt_d  = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q  <= '0;
      high_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      high_q <= high_d;
    end
  end

  assign last_high_o = en_i & high_q & wrap;
  assign rise_tick_o = en_i & ~high_q & wrap;
  // no fall after the final high phase: the frame ends instead
  assign fall_tick_o = last_high_o & ~stop_i;

endmodule

// File: rtl/adc_spi_reader.sv
// SPI master for an 8-channel 12-bit ADC: one 16-bit frame per
// conversion, result tagged with the channel it belongs to.
module adc_spi_reader
  import adc_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2,
  parameter int unsigned DATA_W  = ADC_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [2:0]        channel_addr,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso,
  output logic [DATA_W-1:0] sample_data,
  output logic [2:0]        sample_chan,
  output logic              sample_valid,
  output logic              busy
);

  state_e state_q, state_d;

  logic [3:0]            bit_q, bit_d;
  logic [7:0]            gap_q, gap_d;
  logic [2:0]            cur_chan_q, cur_chan_d;
  logic [2:0]            prev_chan_q, prev_chan_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] shift_nxt;
  logic                  miso_s1_q, miso_s2_q;

  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [2:0]        chan_q, chan_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic gen_en, last_bit;
  logic fall_tick, rise_tick, last_high;

  assign gen_en   = (state_q == SETUP) | (state_q == SHIFT);
  assign last_bit = (bit_q == 4'(FRAME_BITS - 1));

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk        (clk),
    .resetn     (resetn),
    .en_i       (gen_en),
    .stop_i     (last_bit),
    .fall_tick_o(fall_tick),
    .rise_tick_o(rise_tick),
    .last_high_o(last_high)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (en) state_d = SETUP;
      end
      SETUP: begin
        if (last_high) state_d = SHIFT;
      end
      SHIFT: begin
        if (last_high && last_bit) state_d = GAP;
      end
      GAP: begin
        if (gap_q == 8'(CS_GAP - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign shift_nxt = {shift_q[FRAME_BITS-2:0], miso_s2_q};

  always_comb begin
    bit_d       = bit_q;
    gap_d       = '0;
    cur_chan_d  = cur_chan_q;
    prev_chan_d = prev_chan_q;
    shift_d     = shift_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    data_d      = data_q;
    chan_d      = chan_q;
    valid_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        bit_d  = '0;
        mosi_d = 1'b0;
        if (en) begin
          cs_n_d     = 1'b0;
          cur_chan_d = channel_addr;
        end
      end
      SETUP: begin
        if (fall_tick) begin
          sclk_d = 1'b0;
          mosi_d = addr_bit(4'd0, cur_chan_q);
          bit_d  = '0;
        end
      end
      SHIFT: begin
        if (rise_tick) sclk_d = 1'b1;
        if (last_high) begin
          shift_d = shift_nxt;
          bit_d   = bit_q + 4'd1;
          if (fall_tick) begin
            sclk_d = 1'b0;
            mosi_d = addr_bit(bit_q + 4'd1, cur_chan_q);
          end else begin
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            valid_d = 1'b1;
            data_d  = shift_nxt[DATA_W-1:0];
            // ADC answers with the channel addressed one frame earlier
            chan_d      = prev_chan_q;
            prev_chan_d = cur_chan_q;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 8'd1;
      end
      default: ;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      bit_q       <= '0;
      gap_q       <= '0;
      cur_chan_q  <= '0;
      prev_chan_q <= '0;
      shift_q     <= '0;
      miso_s1_q   <= 1'b0;
      miso_s2_q   <= 1'b0;
      sclk_q      <= 1'b1;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      data_q      <= '0;
      chan_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      cur_chan_q  <= cur_chan_d;
      prev_chan_q <= prev_chan_d;
      shift_q     <= shift_d;
      miso_s1_q   <= miso;
      miso_s2_q   <= miso_s1_q;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      data_q      <= data_d;
      chan_q      <= chan_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign sclk         = sclk_q;
  assign cs_n         = cs_n_q;
  assign mosi         = mosi_q;
  assign sample_data  = data_q;
  assign sample_chan  = chan_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: two instances (CLK_DIV 4/GAP 2 and 3/1),
// a frame-offset reference model, an ADC DOUT model and literal pins.
module tb_adc_spi_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] resetn_v, en_v, miso_v;
  logic [1:0] sclk_v, cs_v, mosi_v, valid_v, busy_v;
  logic [2:0]  addr_v [2];
  logic [2:0]  chan_v [2];
  logic [11:0] data_v [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    adc_spi_reader #(
      .CLK_DIV(g == 0 ? 4 : 3),
      .CS_GAP (g == 0 ? 2 : 1),
      .DATA_W (12)
    ) u_dut (
      .clk         (clk),
      .resetn      (resetn_v[g]),
      .en          (en_v[g]),
      .channel_addr(addr_v[g]),
      .sclk        (sclk_v[g]),
      .cs_n        (cs_v[g]),
      .mosi        (mosi_v[g]),
      .miso        (miso_v[g]),
      .sample_data (data_v[g]),
      .sample_chan (chan_v[g]),
      .sample_valid(valid_v[g]),
      .busy        (busy_v[g])
    );
  end

  int checks = 0;
  int fails  = 0;
  int t      = 0;

  function automatic int div_of(input int g);
    return (g == 0) ? 4 : 3;
  endfunction

  function automatic int gap_of(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  // Reference model: position inside the frame as a plain offset
  bit          on   [2];
  bit          act  [2];
  int          off  [2];
  logic [2:0]  cur  [2];
  logic [2:0]  prev [2];
  logic [2:0]  hchan[2];
  logic [11:0] fdat [2];
  logic [11:0] hdat [2];
  logic [11:0] dq0[$];
  logic [11:0] dq1[$];

  initial begin
    for (int g = 0; g < 2; g++) begin
      on[g] = 0; act[g] = 0; off[g] = 0;
      cur[g] = 0; prev[g] = 0; hchan[g] = 0;
      fdat[g] = 0; hdat[g] = 0;
    end
    forever begin
      @(posedge clk);
      for (int g = 0; g < 2; g++) begin
        if (!resetn_v[g]) begin
          on[g] = 1; act[g] = 0; off[g] = 0;
          prev[g] = 0; hdat[g] = 0; hchan[g] = 0;
        end else if (!act[g]) begin
          if (en_v[g]) begin
            act[g] = 1;
            off[g] = 1;
            cur[g] = addr_v[g];
            if (g == 0 && dq0.size() > 0)
              fdat[g] = dq0.pop_front();
            else if (g == 1 && dq1.size() > 0)
              fdat[g] = dq1.pop_front();
            else
              fdat[g] = 12'($urandom);
          end
        end else begin
          off[g]++;
          if (off[g] == 33 * div_of(g) + 1) begin
            hdat[g]  = fdat[g];
            hchan[g] = prev[g];
            prev[g]  = cur[g];
          end
          if (off[g] > 33 * div_of(g) + gap_of(g))
            act[g] = 0;
        end
      end
    end
  end

  function automatic logic [19:0] expect_out(input int g);
    int d, p, k;
    logic sc, cs, mo, va, bu;
    d = div_of(g);
    sc = 1; cs = 1; mo = 0; va = 0; bu = 0;
    if (act[g]) begin
      bu = 1;
      if (off[g] <= d) begin
        cs = 0;
      end else if (off[g] <= 33 * d) begin
        cs = 0;
        p  = off[g] - d - 1;
        k  = p / (2 * d);
        sc = ((p % (2 * d)) >= d);
        mo = (k >= 2 && k <= 4) ? cur[g][4 - k] : 1'b0;
      end else begin
        va = (off[g] == 33 * d + 1);
      end
    end
    return {sc, cs, mo, va, bu, hchan[g], hdat[g]};
  endfunction

  // ADC model: DOUT bit k appears lag cycles after SCLK fall k
  initial begin
    logic [15:0] word [2];
    int k [2], pcnt [2], lag [2];
    bit pend [2];
    logic cs_p [2], sc_p [2];
    miso_v = '0;
    for (int g = 0; g < 2; g++) begin
      word[g] = 0; k[g] = 0; pcnt[g] = 0; lag[g] = 0;
      pend[g] = 0; cs_p[g] = 1; sc_p[g] = 1;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        if (cs_v[g] !== 1'b0) begin
          pend[g]   = 0;
          miso_v[g] = 1'($urandom);
        end else begin
          if (cs_p[g] === 1'b1) begin
            word[g] = {4'($urandom), fdat[g]};
            k[g]    = 0;
            pend[g] = 0;
            lag[g]  = (g == 0) ? int'($urandom_range(0, 3)) : 1;
          end
          if (sc_p[g] === 1'b1 && sclk_v[g] === 1'b0) begin
            pend[g] = 1;
            pcnt[g] = lag[g];
          end
          if (pend[g]) begin
            if (pcnt[g] == 0) begin
              if (k[g] < 16) miso_v[g] = word[g][15 - k[g]];
              k[g]++;
              pend[g] = 0;
            end else begin
              pcnt[g]--;
            end
          end
        end
        cs_p[g] = cs_v[g];
        sc_p[g] = sclk_v[g];
      end
    end
  end

  // Every-cycle comparison against the model
  initial begin
    logic [19:0] ex, ac;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (on[g]) begin
          ex = expect_out(g);
          ac = {sclk_v[g], cs_v[g], mosi_v[g], valid_v[g],
                busy_v[g], chan_v[g], data_v[g]};
          checks++;
          if (ac !== ex) begin
            fails++;
            $display("FAIL model dut%0d t=%0t got=%05h want=%05h",
                     g, $time, ac, ex);
          end
        end
      end
    end
  end

  task automatic run_to(input int c);
    while (t < c) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  task automatic do_reset(input int g);
    resetn_v[g] = 1'b0;
    en_v[g]     = 1'b0;
    repeat (3) @(negedge clk);
    resetn_v[g] = 1'b1;
    @(negedge clk);
  endtask

  task automatic random_run(input int g, input int n);
    en_v[g] = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      addr_v[g] = 3'($urandom);
      if ($urandom_range(0, 99) == 0) en_v[g] = ~en_v[g];
      resetn_v[g] = ($urandom_range(0, 999) != 0);
    end
    resetn_v[g] = 1'b1;
    en_v[g]     = 1'b0;
    repeat (160) @(negedge clk);
  endtask

  initial begin
    resetn_v  = '0;
    en_v      = '0;
    addr_v[0] = '0;
    addr_v[1] = '0;

    do_reset(0);
    lit("rst_cs_n", 32'(cs_v[0]), 1);
    lit("rst_sclk", 32'(sclk_v[0]), 1);
    lit("rst_mosi", 32'(mosi_v[0]), 0);
    lit("rst_valid", 32'(valid_v[0]), 0);
    lit("rst_busy", 32'(busy_v[0]), 0);
    lit("rst_data", 32'(data_v[0]), 0);
    lit("rst_chan", 32'(chan_v[0]), 0);

    // first frame, en dropped mid-frame
    dq0.push_back(12'hABC);
    t = 0; addr_v[0] = 3'b101; en_v[0] = 1'b1;
    run_to(1);   lit("t1_cs_fall", 32'(cs_v[0]), 0);
    run_to(2);   addr_v[0] = 3'b000;
    run_to(4);   lit("t1_setup_sclk", 32'(sclk_v[0]), 1);
    run_to(5);   lit("t1_first_fall", 32'(sclk_v[0]), 0);
    run_to(21);  lit("t1_mosi_k2", 32'(mosi_v[0]), 1);
    run_to(29);  lit("t1_mosi_k3", 32'(mosi_v[0]), 0);
    run_to(37);  lit("t1_mosi_k4", 32'(mosi_v[0]), 1);
    run_to(50);  en_v[0] = 1'b0;
    run_to(132); lit("t1_pre_valid", 32'(valid_v[0]), 0);
    run_to(133); lit("t1_valid", 32'(valid_v[0]), 1);
    lit("t1_data", 32'(data_v[0]), 32'hABC);
    lit("t1_chan", 32'(chan_v[0]), 0);
    run_to(134); lit("t1_valid_pulse", 32'(valid_v[0]), 0);
    run_to(135); lit("t4_busy_low", 32'(busy_v[0]), 0);
    run_to(140); lit("t4_cs_idle", 32'(cs_v[0]), 1);

    // back-to-back frames with channel sequence 2,6,1
    do_reset(0);
    dq0.push_back(12'h123);
    dq0.push_back(12'hFFF);
    dq0.push_back(12'h000);
    t = 0; addr_v[0] = 3'd2; en_v[0] = 1'b1;
    run_to(100); addr_v[0] = 3'd6;
    run_to(133); lit("t2_v1", 32'(valid_v[0]), 1);
    lit("t2_c1", 32'(chan_v[0]), 0);
    lit("t2_d1", 32'(data_v[0]), 32'h123);
    run_to(135); lit("t2_gap_cs", 32'(cs_v[0]), 1);
    run_to(136); lit("t2_cs_fall2", 32'(cs_v[0]), 0);
    run_to(200); addr_v[0] = 3'd1;
    run_to(268); lit("t2_v2", 32'(valid_v[0]), 1);
    lit("t2_c2", 32'(chan_v[0]), 2);
    lit("t2_d2", 32'(data_v[0]), 32'hFFF);
    run_to(300); en_v[0] = 1'b0;
    run_to(403); lit("t2_v3", 32'(valid_v[0]), 1);
    lit("t2_c3", 32'(chan_v[0]), 6);
    lit("t2_d3", 32'(data_v[0]), 32'h000);
    run_to(410);

    // channel_addr changes mid-frame are ignored
    t = 0; addr_v[0] = 3'd7; en_v[0] = 1'b1;
    run_to(3);   addr_v[0] = 3'd0;
    run_to(21);  lit("t3_mosi_k2", 32'(mosi_v[0]), 1);
    run_to(29);  lit("t3_mosi_k3", 32'(mosi_v[0]), 1);
    run_to(37);  lit("t3_mosi_k4", 32'(mosi_v[0]), 1);
    run_to(133); lit("t3_chan_prev", 32'(chan_v[0]), 1);
    run_to(200); en_v[0] = 1'b0;
    run_to(268); lit("t3_valid2", 32'(valid_v[0]), 1);
    lit("t3_chan7", 32'(chan_v[0]), 7);
    run_to(275);

    // reset in the middle of SHIFT
    t = 0; addr_v[0] = 3'd3; en_v[0] = 1'b1;
    run_to(70);  resetn_v[0] = 1'b0;
    run_to(71);
    lit("t5_cs_n", 32'(cs_v[0]), 1);
    lit("t5_sclk", 32'(sclk_v[0]), 1);
    lit("t5_mosi", 32'(mosi_v[0]), 0);
    lit("t5_valid", 32'(valid_v[0]), 0);
    lit("t5_busy", 32'(busy_v[0]), 0);
    lit("t5_data", 32'(data_v[0]), 0);
    resetn_v[0] = 1'b1;
    run_to(72);  lit("t5_restart", 32'(cs_v[0]), 0);
    run_to(204); lit("t5_valid", 32'(valid_v[0]), 1);
    lit("t5_chan0", 32'(chan_v[0]), 0);
    run_to(210); en_v[0] = 1'b0;
    run_to(350);

    random_run(0, 3000);

    // fast divider, short gap, DOUT one clk after each fall
    do_reset(1);
    dq1.push_back(12'h5A5);
    t = 0; addr_v[1] = 3'd4; en_v[1] = 1'b1;
    run_to(4);   lit("t6_first_fall", 32'(sclk_v[1]), 0);
    run_to(100); lit("t6_valid", 32'(valid_v[1]), 1);
    lit("t6_data", 32'(data_v[1]), 32'h5A5);
    run_to(101); lit("t6_idle", 32'(busy_v[1]), 0);
    run_to(102); lit("t6_cs_fall2", 32'(cs_v[1]), 0);
    run_to(201); lit("t6_valid2", 32'(valid_v[1]), 1);
    lit("t6_chan2", 32'(chan_v[1]), 4);
    en_v[1] = 1'b0;
    run_to(320);

    random_run(1, 1500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
